// File: rtl/pipe_datapath_if.sv
// Instruction/result bundle for pipe_datapath: EX-stage instruction fields in,
// WB-stage result, operands, flags and valid out.
interface pipe_datapath_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
);
  logic          in_valid;
  logic [AW-1:0] DA;
  logic [AW-1:0] AA;
  logic [AW-1:0] BA;
  logic [3:0]    FS;
  logic          MB;
  logic [DW-1:0] imm;
  logic [1:0]    resultSource;
  logic          RW;
  logic [DW-1:0] MemIn;
  logic [DW-1:0] PC;
  logic [DW-1:0] MemAddr;
  logic [DW-1:0] Dout;
  logic [DW-1:0] Result;
  logic          out_valid;
  logic [3:0]    flags;

  modport master (
    output in_valid, DA, AA, BA, FS, MB, imm, resultSource, RW, MemIn, PC,
    input  MemAddr, Dout, Result, out_valid, flags
  );

  modport slave (
    input  in_valid, DA, AA, BA, FS, MB, imm, resultSource, RW, MemIn, PC,
    output MemAddr, Dout, Result, out_valid, flags
  );
endinterface

// File: rtl/pipe_datapath.sv
// Two-stage (EX/WB) register-file datapath with ALU and {Z,N,C,V} flags.
// Optional WB->EX operand bypass enabled by defining DP_FORWARD_EN.
module pipe_datapath #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic           clk,
  input  logic           reset,
  pipe_datapath_if.slave bus
);
  localparam int unsigned NREG = 2 ** AW;

  logic [DW-1:0] rf_q [NREG];

  logic          wb_valid_q;
  logic [DW-1:0] wb_alu_q;
  logic [DW-1:0] wb_pc_q;
  logic [AW-1:0] wb_da_q;
  logic          wb_rw_q;
  logic [1:0]    wb_rs_q;
  logic [DW-1:0] mem_addr_q;
  logic [DW-1:0] dout_q;
  logic [3:0]    flags_q;

  logic          wb_we;
  logic [DW-1:0] result_c;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b_reg;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_res;
  logic [DW:0]   sum;
  logic          alu_c;
  logic          alu_v;

  assign wb_we = wb_valid_q && wb_rw_q && (wb_da_q != '0);

  // Writeback mux; MemIn is taken live during the WB cycle
  always_comb begin
    result_c = wb_alu_q;
    case (wb_rs_q)
      2'd1:    result_c = bus.MemIn;
      2'd2:    result_c = wb_pc_q;
      default: result_c = wb_alu_q;
    endcase
  end

  assign rd_a = (bus.AA == '0) ? '0 : rf_q[bus.AA];
  assign rd_b = (bus.BA == '0) ? '0 : rf_q[bus.BA];

`ifdef DP_FORWARD_EN
  assign op_a     = (wb_we && (bus.AA == wb_da_q)) ? result_c : rd_a;
  assign op_b_reg = (wb_we && (bus.BA == wb_da_q)) ? result_c : rd_b;
`else
  assign op_a     = rd_a;
  assign op_b_reg = rd_b;
`endif

  assign op_b = bus.MB ? bus.imm : op_b_reg;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum     = '0;
    case (bus.FS)
      4'd0: begin
        sum     = {1'b0, op_a} + {1'b0, op_b};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (op_a[DW-1] == op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
      end
      4'd1: begin
        sum     = {1'b0, op_a} + {1'b0, ~op_b} + (DW+1)'(1);
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (op_a[DW-1] != op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
      end
      4'd2: alu_res = op_a & op_b;
      4'd3: alu_res = op_a | op_b;
      4'd4: alu_res = op_a ^ op_b;
      4'd5: alu_res = ~op_a;
      4'd6: begin
        alu_res = op_a << 1;
        alu_c   = op_a[DW-1];
      end
      4'd7: begin
        alu_res = op_a >> 1;
        alu_c   = op_a[0];
      end
      4'd8: alu_res = op_b;
      4'd9: begin
        sum     = {1'b0, op_a} + (DW+1)'(1);
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = !op_a[DW-1] && alu_res[DW-1];
      end
      default: alu_res = '0;
    endcase
  end

  // Register file; entry 0 is never written and reads back as zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[wb_da_q] <= result_c;
    end
  end

  // WB stage; payload and flags only move on valid issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_alu_q   <= '0;
      wb_pc_q    <= '0;
      wb_da_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_rs_q    <= '0;
      mem_addr_q <= '0;
      dout_q     <= '0;
      flags_q    <= '0;
    end else begin
      wb_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        wb_alu_q   <= alu_res;
        wb_pc_q    <= bus.PC;
        wb_da_q    <= bus.DA;
        wb_rw_q    <= bus.RW;
        wb_rs_q    <= bus.resultSource;
        mem_addr_q <= op_a;
        dout_q     <= op_b;
        flags_q    <= {(alu_res == '0), alu_res[DW-1], alu_c, alu_v};
      end
    end
  end

  assign bus.Result    = result_c;
  assign bus.MemAddr   = mem_addr_q;
  assign bus.Dout      = dout_q;
  assign bus.out_valid = wb_valid_q;
  assign bus.flags     = flags_q;
endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 SHALL have parameter DW, default 16: datapath width in bits.
REQ-002 SHALL have parameter AW, default 4: register address width; register count 2**AW.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  instruction present this cycle.
REQ-006 SHALL have ports DA, AA, BA  in  AW each  destination, operand-A and operand-B register addresses.
REQ-007 SHALL have port FS  in  4  ALU function select.
REQ-008 SHALL have port MB  in  1  operand-B source: 0 register BA, 1 imm.
REQ-009 SHALL have port imm  in  DW  immediate operand.
REQ-010 SHALL have port resultSource  in  2  writeback source select.
REQ-011 SHALL have port RW  in  1  register write enable for this instruction.
REQ-012 SHALL have ports MemIn and PC  in  DW each  memory read data and program counter.
REQ-013 SHALL have ports MemAddr and Dout  out  DW each  registered operand A and operand B (post-MB).
REQ-014 SHALL have port Result  out  DW  writeback value of the WB-stage instruction.
REQ-015 SHALL have port out_valid  out  1  WB stage holds a valid instruction.
REQ-016 SHALL have port flags  out  4  registered {Z,N,C,V}.

Function
REQ-017 SHALL contain 2**AW registers of DW bits each, read asynchronously and written synchronously; register 0 SHALL read as zero and ignore writes.
REQ-018 SHALL form two stages: EX (operand read and ALU, combinational) and WB (registered). On an edge with in_valid=1, EX results, DA, RW, resultSource, PC, operand A and operand B SHALL be captured into WB, and out_valid SHALL be 1 next cycle; on an edge with in_valid=0, out_valid SHALL be 0 next cycle.
REQ-019 SHALL implement FS encoding: 0 A+B, 1 A-B, 2 A&B, 3 A|B, 4 A^B, 5 ~A, 6 A<<1, 7 A>>1 logical, 8 B, 9 A+1; codes 10-15 SHALL yield 0.
REQ-020 SHALL produce results modulo 2**DW.
REQ-021 Z SHALL be 1 iff the ALU result is 0; N SHALL be the result MSB.
REQ-022 C SHALL be the carry-out of A+B (ADD), of A+~B+1 (SUB), and of A+1 (INC); for SHL it SHALL be A[DW-1], for SHR A[0]; for all other codes 0.
REQ-023 V SHALL be signed overflow for ADD, SUB and INC, else 0.
REQ-024 flags SHALL update only on edges with in_valid=1 and SHALL otherwise hold.
REQ-025 Result SHALL be selected by the WB-stage resultSource: 0 ALU result, 1 MemIn (sampled live during the WB cycle), 2 captured PC, 3 ALU result.
REQ-026 At the edge ending a WB cycle with out_valid=1, RW=1 and DA!=0, Result SHALL be written to register DA; otherwise no register SHALL change.
REQ-027 MemAddr and Dout SHALL hold the operands of the WB-stage instruction; MemIn therefore SHALL be consumed one cycle after issue.
REQ-028 Back-to-back valid instructions SHALL be accepted every cycle with no stall.

Reset
REQ-029 When reset is asserted, all registers, the WB stage, flags, MemAddr, Dout and out_valid SHALL clear to 0 immediately, without waiting for clk.
REQ-030 A WB-stage instruction present when reset asserts SHALL be discarded with no register write.
REQ-031 The first edge after reset deasserts SHALL accept an instruction normally.

Configuration
REQ-032 With DP_FORWARD_EN defined, if an EX-stage read address (AA or BA) equals the DA of a WB-stage instruction that will write (REQ-026), the EX operand SHALL be taken from Result; AA and BA SHALL be bypassed independently.
REQ-033 Without DP_FORWARD_EN, EX reads SHALL return the pre-write register value; software SHALL insert one non-writing cycle between dependent instructions.

Verification (DW=16, AW=4)
REQ-034 Reset, then r1=5 via FS=8,MB=1,imm=5,DA=1,RW=1; next cycle r2=7 likewise; then FS=0,AA=1,BA=2,DA=3 -> Result=12, flags=0000, r3=12 after WB.
REQ-035 Load r1=0x7FFF, then FS=9,AA=1 -> Result=0x8000, flags N=1,V=1,C=0,Z=0; then load r1=0xFFFF, then FS=9,AA=1 -> Result=0, Z=1, C=1.
REQ-036 Issue r4=3, then next cycle FS=0,AA=4,BA=4,DA=5 -> r5=6 with DP_FORWARD_EN defined, r5=0 without it.
REQ-037 Write DA=0, imm=0xABCD, RW=1 -> Result=0xABCD with out_valid=1, but register 0 still reads 0; also resultSource=1 with MemIn=0x1234 -> Result=0x1234; resultSource=2 with PC=15 -> Result=15.
REQ-038 Issue a writing instruction and assert reset mid-cycle during its WB stage -> out_valid, MemAddr and Dout go 0 at once; the target register stays 0.
